// File: rtl/pipe_stage_regs.sv
// Elastic inter-stage pipeline register: valid/ready handshake, 2-entry skid buffer,
// sync flush, saturating stall counter. Define PIPE_STAGE_DEBUG_INSTR_EN to carry a 32-bit instruction word.
module pipe_stage_regs #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
`ifdef PIPE_STAGE_DEBUG_INSTR_EN
    input  logic [31:0]       in_instr,
    output logic [31:0]       out_instr,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_m_data, r_s_data;
    logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_m_vld, w_acc, w_drn;
    logic              w_m_ld_in, w_m_ld_skid, w_s_ld;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_m_vld = (r_state != ST_EMPTY);
    assign w_acc   = in_valid & r_in_ready & ~flush;
    assign w_drn   = w_m_vld & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_acc) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_acc && !w_drn)      w_state_nxt = ST_FULL;
                    else if (!w_acc && w_drn) w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_drn) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Slot load enables
    always_comb begin
        w_m_ld_in   = 1'b0;
        w_m_ld_skid = 1'b0;
        w_s_ld      = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: w_m_ld_in = w_acc;
                ST_ONE: begin
                    w_m_ld_in = w_acc & w_drn;
                    w_s_ld    = w_acc & ~w_drn;
                end
                ST_FULL:  w_m_ld_skid = w_drn;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_data <= '0;
            r_s_data <= '0;
        end else begin
            if (w_m_ld_in)        r_m_data <= in_data;
            else if (w_m_ld_skid) r_m_data <= r_s_data;
            if (w_s_ld)           r_s_data <= in_data;
        end
    end

    // Control bundle is cleared on flush so a bubble can never carry enables
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_ctrl <= '0;
            r_s_ctrl <= '0;
        end else if (flush) begin
            r_m_ctrl <= '0;
            r_s_ctrl <= '0;
        end else begin
            if (w_m_ld_in)        r_m_ctrl <= in_ctrl;
            else if (w_m_ld_skid) r_m_ctrl <= r_s_ctrl;
            if (w_s_ld)           r_s_ctrl <= in_ctrl;
        end
    end

`ifdef PIPE_STAGE_DEBUG_INSTR_EN
    logic [31:0] r_m_instr, r_s_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_instr <= '0;
            r_s_instr <= '0;
        end else begin
            if (w_m_ld_in)        r_m_instr <= in_instr;
            else if (w_m_ld_skid) r_m_instr <= r_s_instr;
            if (w_s_ld)           r_s_instr <= in_instr;
        end
    end

    assign out_instr = w_m_vld ? r_m_instr : 32'd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       r_stall_cnt <= '0;
        else if (stall_clr)             r_stall_cnt <= '0;
        else if (w_m_vld && !out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_m_vld;
    assign out_data  = r_m_data;
    assign out_ctrl  = w_m_vld ? r_m_ctrl : '0;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: streaming, skid/backpressure, flush,
// stall counter saturation, async reset, and the optional instruction lane.
module tb_pipe_stage_regs;

    localparam int DW = 96;
    localparam int CW = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;
    logic          stall_clr;
`ifdef PIPE_STAGE_DEBUG_INSTR_EN
    logic [31:0]   in_instr;
    logic [31:0]   out_instr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    pipe_stage_regs #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
`ifdef PIPE_STAGE_DEBUG_INSTR_EN
        .in_instr  (in_instr),
        .out_instr (out_instr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    localparam logic [DW-1:0] D1 = {32'hDEADBEEF, 64'h1};
    localparam logic [DW-1:0] DA = 96'hA;
    localparam logic [DW-1:0] DB = 96'hB;

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
        drive(1'b0, '0, '0);
`ifdef PIPE_STAGE_DEBUG_INSTR_EN
        in_instr = '0;
`endif
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_stall",     stall_cnt, 0);
        tick();
        rst = 1'b1;
        chk("rel_in_ready_low", in_ready, 0);
        tick();
        chk("rel_in_ready_high", in_ready, 1);

        // Streaming 1,2,3 with out_ready high
        out_ready = 1'b1;
        drive(1'b1, D1, 16'h0005);
        tick();
        chk("s1_valid", out_valid, 1);
        chk("s1_data",  out_data,  D1);
        chk("s1_ctrl",  out_ctrl,  16'h0005);
        drive(1'b1, 96'h2, 16'h0006);
        tick();
        chk("s2_data", out_data, 96'h2);
        chk("s2_ctrl", out_ctrl, 16'h0006);
        drive(1'b1, 96'h3, 16'h0007);
        tick();
        chk("s3_data", out_data, 96'h3);
        drive(1'b0, '0, '0);
        tick();
        chk("s_end_valid", out_valid, 0);
        chk("s_end_ctrl",  out_ctrl,  0);
        chk("s_stall",     stall_cnt, 0);

        // Backpressure: A, B fill both slots
        out_ready = 1'b0;
        drive(1'b1, DA, 16'h0011);
        tick();
        chk("bp_a_data", out_data, DA);
        chk("bp_a_rdy",  in_ready, 1);
        drive(1'b1, DB, 16'h0022);
        tick();
        chk("bp_full_rdy", in_ready, 0);
        chk("bp_full_data", out_data, DA);
        chk("bp_stall1", stall_cnt, 1);
        drive(1'b1, 96'hEE, 16'h00EE);
        tick();
        tick();
        chk("bp_hold_data", out_data, DA);
        chk("bp_hold_ctrl", out_ctrl, 16'h0011);
        chk("bp_stall3", stall_cnt, 3);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        tick();
        chk("bp_b_data", out_data, DB);
        chk("bp_b_ctrl", out_ctrl, 16'h0022);
        chk("bp_b_rdy",  in_ready, 1);
        chk("bp_stall_keep", stall_cnt, 3);
        tick();
        chk("bp_empty", out_valid, 0);

        // Flush from FULL with C offered
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 96'h1A, 16'h0013);
        tick();
        drive(1'b1, 96'h1B, 16'h0014);
        tick();
        chk("fl_full_rdy", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 96'hC, 16'h0033);
        tick();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl",  out_ctrl,  0);
        chk("fl_rdy",   in_ready,  1);
        chk("fl_stall", stall_cnt, 2);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        tick();
        chk("fl_no_c", out_valid, 0);

        // Flush from ONE while in_ready is high: offered C must still be dropped
        drive(1'b1, 96'hD, 16'h0044);
        tick();
        chk("fl1_d", out_data, 96'hD);
        flush = 1'b1;
        drive(1'b1, 96'hC, 16'h0033);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("fl1_valid", out_valid, 0);
        tick();
        chk("fl1_no_c", out_valid, 0);

        // Stall counter saturation and clear priority
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 96'hE, 16'h0055);
        tick();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_15", stall_cnt, 15);
        stall_clr = 1'b1;
        tick();
        chk("sat_clr", stall_cnt, 0);
        stall_clr = 1'b0;
        tick();
        chk("sat_inc_after_clr", stall_cnt, 1);

        // Async reset mid-cycle in FULL
        drive(1'b1, 96'hF, 16'h0066);
        tick();
        drive(1'b0, '0, '0);
        chk("ar_full_rdy", in_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data",  out_data,  0);
        chk("ar_ctrl",  out_ctrl,  0);
        chk("ar_rdy",   in_ready,  0);
        chk("ar_stall", stall_cnt, 0);
        #2;
        rst = 1'b1;
        tick();
        chk("ar_rel_rdy",   in_ready,  1);
        chk("ar_rel_valid", out_valid, 0);
        out_ready = 1'b1;
        drive(1'b1, 96'h77, 16'h0009);
        tick();
        chk("ar_g_data", out_data, 96'h77);
        chk("ar_g_ctrl", out_ctrl, 16'h0009);
        drive(1'b0, '0, '0);
        tick();
        chk("ar_no_stale", out_valid, 0);

`ifdef PIPE_STAGE_DEBUG_INSTR_EN
        // Instruction lane under intermittent out_ready
        out_ready = 1'b0;
        drive(1'b1, 96'h100, 16'h0001);
        in_instr = 32'h00500093;
        tick();
        chk("in_i1", out_instr, 32'h00500093);
        drive(1'b1, 96'h104, 16'h0002);
        in_instr = 32'h00A00113;
        tick();
        chk("in_i1_hold", out_instr, 32'h00500093);
        drive(1'b0, '0, '0);
        in_instr = 32'hFFFFFFFF;
        out_ready = 1'b1;
        tick();
        chk("in_i2", out_instr, 32'h00A00113);
        chk("in_i2_data", out_data, 96'h104);
        tick();
        chk("in_bubble", out_instr, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Parametrised, elastic inter-stage pipeline register. Replaces the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a DATA_W datapath bundle and a CTRL_W control bundle.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure never has a combinational path from out_ready to in_ready.
- Synchronous flush inserts bubbles for branch and hazard recovery. A saturating stall counter supports performance debug.

Parameters:
- DATA_W, 96: width of the datapath bundle (PC, operands, immediate, register indices).
- CTRL_W, 16: width of the control bundle (RegWrite, MemWrite, MemRead, ALU control, ...). Forced to zero in bubbles.
- CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous reset, active-low. Asserted when rst = 0.
- flush, input, 1: synchronous flush. Discards all held entries and any input offered this cycle.
- in_valid, input, 1: upstream has a valid entry.
- in_ready, output, 1: block can accept an entry. Registered.
- in_data, input, DATA_W: upstream datapath bundle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream accepts the head entry.
- out_data, output, DATA_W: head datapath bundle.
- out_ctrl, output, CTRL_W: head control bundle. Equals 0 whenever out_valid = 0.
- stall_cnt, output, CNT_W: number of cycles with out_valid=1 and out_ready=0. Saturating.
- stall_clr, input, 1: synchronous clear of stall_cnt.

Behaviour:
- Storage: main slot (M), which drives the outputs, and skid slot (S). Each slot has a valid bit.
- States:
  - EMPTY: M and S invalid.
  - ONE: M valid only.
  - FULL: M and S valid.
- Accept condition: acc = in_valid & in_ready & ~flush.
- Drain condition: drn = out_valid & out_ready.
- in_ready = registered ~S.valid. It is 1 in EMPTY and ONE, and 0 in FULL.
- Transitions (when flush = 0):
  - EMPTY, acc -> ONE. M <= in. Latency is 1 cycle from accept to out_valid.
  - ONE, acc & drn -> ONE. M <= in.
  - ONE, acc & ~drn -> FULL. S <= in.
  - ONE, ~acc & drn -> EMPTY.
  - FULL, drn -> ONE. M <= S. No accept is possible in FULL.
  - Otherwise the state is held and the data is stable.
- Ordering: strictly FIFO. No entry is duplicated or dropped unless flush is asserted.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_ctrl must not change.
- Flush:
  - Next state is EMPTY.
  - Both valid bits are cleared, so the next cycle has out_valid = 0 and out_ctrl = 0.
  - in_ready = 1 on the next cycle.
  - The input offered in the flush cycle is dropped.
  - Data registers may keep stale values. Control registers are cleared.
- Control masking: out_ctrl = M.ctrl when M is valid, otherwise 0. A bubble therefore never asserts a write or memory enable.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - stall_clr has priority over increment. On a clear cycle the result is 0.
  - flush does not affect stall_cnt.
- Reset (rst = 0, asynchronous):
  - State is EMPTY. All data and control registers are 0.
  - Outputs: out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - in_ready=0 while reset is asserted, and 1 from the first clock edge after release.
  - Reset mid-transfer discards all entries.

Optional Feature:
- Macro: PIPE_STAGE_DEBUG_INSTR_EN.
- When defined:
  - Adds ports in_instr (input, 32) and out_instr (output, 32).
  - The instruction word travels alongside the entry through M and S with identical handshake and ordering.
  - out_instr reads 0 when out_valid = 0 and after reset.
  - flush does not clear the instruction registers, but out_instr is masked to 0 while out_valid = 0.
- When undefined: the ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Reset release, then in_valid=1, in_data=0x...01, in_ctrl=0x0005, out_ready=1 -> out_valid=1 the next cycle with out_ctrl=0x0005. Back-to-back streaming of 1,2,3 gives one output per cycle in order. stall_cnt=0.
- Push entries A and B with out_ready=0 -> state FULL, in_ready=0 the cycle after B, out_data=A held stable. After 3 stall cycles stall_cnt=3. Raise out_ready -> A then B appear on consecutive cycles, and in_ready returns to 1.
- FULL state, then flush=1 with in_valid=1 offering C -> next cycle out_valid=0, out_ctrl=0, in_ready=1. C is never output.
- CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Assert stall_clr and stall together -> stall_cnt=0.
- Assert rst=0 asynchronously mid-cycle in FULL state -> outputs go to 0 immediately, without waiting for a clock edge. After release, the first accepted entry appears with no stale A or B.
- With PIPE_STAGE_DEBUG_INSTR_EN defined, push instructions 0x00500093 and 0x00A00113 under intermittent out_ready -> out_instr matches its entry every cycle. out_instr=0 during bubbles.
